// File: rtl/parity_frame_checker_pkg.sv
// rtl/parity_frame_checker_pkg.sv - Shared FSM state type and default parameters for the parity frame checker
package parity_frame_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_BEATS  = 4;
  localparam int DEF_ODD    = 0;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/parity_beat_check.sv
// rtl/parity_beat_check.sv - Combinational per-beat parity evaluator (1 = parity failure)
module parity_beat_check
  import parity_frame_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ODD    = DEF_ODD
) (
  input  logic [DATA_W-1:0] beat_data_i,
  input  logic              beat_par_i,
  output logic              beat_err_o
);

  localparam logic ODD_BIT = (ODD != 0);

  assign beat_err_o = ^{beat_data_i, beat_par_i, ODD_BIT};

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - Frame-level parity checker: beat accumulation FSM and held result
// Optional saturating erroneous-frame counter enabled by defining PARITY_ERR_CNT_EN.
module parity_frame_checker
  import parity_frame_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS,
  parameter int ODD    = DEF_ODD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PARITY_ERR_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt,
`endif
  output logic              out_err,
  output logic [BEATS-1:0]  out_mask
);

  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [BEATS-1:0] mask_q;
  logic [BEATS-1:0] mask_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_err_q;
  logic [BEATS-1:0] out_mask_q;
  logic             beat_err;
  logic             accept;
  logic             res_hs;

  parity_beat_check #(
    .DATA_W(DATA_W),
    .ODD   (ODD)
  ) u_beat_check (
    .beat_data_i(in_data),
    .beat_par_i (in_par),
    .beat_err_o (beat_err)
  );

  assign accept = in_valid && in_ready_q;
  assign res_hs = out_valid_q && out_ready;

  // Outside ACCUM the accumulator reads as empty, so each frame starts from a clean mask.
  always_comb begin
    mask_d        = (state_q == ACCUM) ? mask_q : '0;
    mask_d[idx_q] = mask_d[idx_q] | beat_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              state_q     <= HOLD;
              idx_q       <= '0;
              mask_q      <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_mask_q  <= mask_d;
              out_err_q   <= |mask_d;
            end else begin
              state_q <= ACCUM;
              idx_q   <= idx_q + IDX_W'(1);
              mask_q  <= mask_d;
            end
          end
        end
        HOLD: begin
          // in_ready stays low through the handshake cycle, so no beat can slip in alongside it.
          if (res_hs) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_mask_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_mask  = out_mask_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (cnt_clr) begin
      err_cnt_q <= '0;
    end else if (res_hs && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - Self-checking bench: even and odd instances against a popcount reference model
module tb_parity_frame_checker;

  localparam int DW      = 4;
  localparam int NB      = 4;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_par    = 1'b0;
  logic          out_ready = 1'b0;
  logic          cnt_clr   = 1'b0;

  logic          ir_e, ir_o, ov_e, ov_o, err_e, err_o;
  logic [NB-1:0] mask_e, mask_o;
  logic [CW-1:0] cnt_e, cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fd [NB];
  logic [NB-1:0] fp;
  logic [NB-1:0] em_e, em_o;
  int            exp_cnt_e = 0;
  int            exp_cnt_o = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(DW), .BEATS(NB), .ODD(0), .CNT_W(CW)) dut_even (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (ir_e),
    .in_data  (in_data),
    .in_par   (in_par),
    .out_valid(ov_e),
    .out_ready(out_ready),
`ifdef PARITY_ERR_CNT_EN
    .cnt_clr  (cnt_clr),
    .err_cnt  (cnt_e),
`endif
    .out_err  (err_e),
    .out_mask (mask_e)
  );

  parity_frame_checker #(.DATA_W(DW), .BEATS(NB), .ODD(1), .CNT_W(CW)) dut_odd (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (ir_o),
    .in_data  (in_data),
    .in_par   (in_par),
    .out_valid(ov_o),
    .out_ready(out_ready),
`ifdef PARITY_ERR_CNT_EN
    .cnt_clr  (cnt_clr),
    .err_cnt  (cnt_o),
`endif
    .out_err  (err_o),
    .out_mask (mask_o)
  );

`ifndef PARITY_ERR_CNT_EN
  assign cnt_e = '0;
  assign cnt_o = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A beat fails when its data ones, its parity bit and the mode bit add up to an odd number.
  function automatic logic [NB-1:0] model_mask(input int odd);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++)
      m[i] = ((($countones(fd[i]) + int'(fp[i]) + odd) % 2) == 1);
    return m;
  endfunction

  task automatic check_cnt(input string tag);
`ifdef PARITY_ERR_CNT_EN
    check({tag, "_cnt_even"}, 32'(cnt_e), 32'(exp_cnt_e));
    check({tag, "_cnt_odd"}, 32'(cnt_o), 32'(exp_cnt_o));
`endif
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic p, input int gap);
    int waited;
    waited = 0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    while (!(ir_e && ir_o) && waited < 20) begin
      tick();
      waited++;
    end
    check("beat_ready", {ir_o, ir_e}, 2'b11);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < NB; i++) begin
      send_beat(fd[i], fp[i], gap);
      if (i < NB - 1) check("no_early_valid", {ov_o, ov_e}, 2'b00);
    end
    check("latency_valid", {ov_o, ov_e}, 2'b11);
    em_e = model_mask(0);
    em_o = model_mask(1);
    check("mask_even", mask_e, em_e);
    check("mask_odd", mask_o, em_o);
    check("err_even", err_e, |em_e);
    check("err_odd", err_o, |em_o);
    check("hold_not_ready", {ir_o, ir_e}, 2'b00);
  endtask

  task automatic handshake(input int delay, input logic clr, input logic offer);
    if (offer) begin
      in_valid = 1'b1;
      in_data  = 4'b0001;
      in_par   = 1'b0;
    end
    repeat (delay) begin
      tick();
      check("stall_valid", {ov_o, ov_e, ir_o, ir_e}, 4'b1100);
      check("stall_mask", {mask_o, mask_e}, {em_o, em_e});
      check("stall_err", {err_o, err_e}, {|em_o, |em_e});
    end
    out_ready = 1'b1;
    cnt_clr   = clr;
    tick();
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_hs", {ir_o, ir_e, ov_o, ov_e}, 4'b1100);
    check("zero_when_invalid", {err_o, err_e, mask_o, mask_e}, '0);
    if (clr) exp_cnt_e = 0;
    else if (|em_e && exp_cnt_e < CNT_MAX) exp_cnt_e++;
    if (clr) exp_cnt_o = 0;
    else if (|em_o && exp_cnt_o < CNT_MAX) exp_cnt_o++;
    check_cnt("hs");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_outputs", {ov_o, ov_e, err_o, err_e, mask_o, mask_e}, '0);
    rst_n = 1'b1;
    exp_cnt_e = 0;
    exp_cnt_o = 0;
    tick();
    check("rst_ready", {ir_o, ir_e}, 2'b11);
    check("rst_no_valid", {ov_o, ov_e}, 2'b00);
    check_cnt("rst");
  endtask

  task automatic load(input logic [DW-1:0] d0, input logic p0, input logic [DW-1:0] d1, input logic p1,
                      input logic [DW-1:0] d2, input logic p2, input logic [DW-1:0] d3, input logic p3);
    fd[0] = d0; fd[1] = d1; fd[2] = d2; fd[3] = d3;
    fp    = {p3, p2, p1, p0};
  endtask

  initial begin
    tick();
    do_reset();

    // Clean frame, then a single bad beat at index 2.
    load(4'b1010, 1'b0, 4'b0111, 1'b1, 4'b0000, 1'b0, 4'b1111, 1'b0);
    send_frame(0);
    check("clean_mask_const", mask_e, 4'b0000);
    handshake(0, 1'b0, 1'b0);

    load(4'b1010, 1'b0, 4'b0111, 1'b1, 4'b0001, 1'b0, 4'b1111, 1'b0);
    send_frame(0);
    check("bad2_mask_const", mask_e, 4'b0100);
    handshake(1, 1'b0, 1'b0);

    // Backpressure with a beat offered throughout the hold and handshake cycles.
    load(4'b0011, 1'b1, 4'b0101, 1'b0, 4'b1110, 1'b1, 4'b1000, 1'b1);
    send_frame(0);
    handshake(5, 1'b0, 1'b1);
    load(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    send_frame(0);
    handshake(0, 1'b0, 1'b0);

    // Reset mid-frame after two beats, then a fresh frame.
    load(4'b0001, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    send_beat(fd[0], fp[0], 0);
    send_beat(fd[1], fp[1], 0);
    do_reset();
    load(4'b1100, 1'b0, 4'b0000, 1'b1, 4'b1011, 1'b1, 4'b0110, 1'b0);
    send_frame(0);
    handshake(0, 1'b0, 1'b0);

    // Reset while a result is pending discards it.
    send_frame(0);
    do_reset();

    // Gaps of three idle cycles between beats.
    load(4'b1000, 1'b0, 4'b1100, 1'b0, 4'b1000, 1'b0, 4'b1100, 1'b0);
    send_frame(3);
    check("odd_gap_mask_const", mask_o, 4'b1010);
    handshake(0, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NB; i++) begin
        fd[i] = DW'($urandom);
        fp[i] = 1'($urandom_range(0, 1));
      end
      send_frame(int'($urandom_range(0, 2)));
      handshake(int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
    end

`ifdef PARITY_ERR_CNT_EN
    do_reset();
    load(4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    for (int f = 0; f < 5; f++) begin
      send_frame(0);
      handshake(0, 1'b0, 1'b0);
    end
    check("cnt_saturated", 32'(cnt_e), 32'(CNT_MAX));
    send_frame(0);
    handshake(0, 1'b1, 1'b0);
    check("cnt_clr_wins", 32'(cnt_e), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
